// File: rtl/iir_pkg.sv
// Shared definitions for the iir_filter control slice: word width,
// coefficient register addresses and the commit-sequence states.
package iir_pkg;

   localparam int NB = 12;

   localparam logic [2:0] A_B0 = 3'd0;
   localparam logic [2:0] A_B1 = 3'd1;
   localparam logic [2:0] A_B2 = 3'd2;
   localparam logic [2:0] A_A1 = 3'd3;
   localparam logic [2:0] A_A2 = 3'd4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SWAP  = 2'd2,
      CLEAR = 2'd3
   } state_t;

endpackage

// File: rtl/inflight_cnt.sv
// Up/down count of samples handed to the filter but not yet returned.
// Saturates at MAX; a decrement at zero raises underflow and is dropped.
module inflight_cnt #(
   parameter int MAX = 7,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         underflow
);

   assign underflow = dec & (cnt == '0);

   // Simultaneous inc and dec cancel, so only the one-sided cases move the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc & ~dec) begin
         if (cnt != W'(MAX))
            cnt <= cnt + W'(1);
      end else if (dec & ~inc) begin
         if (cnt != '0)
            cnt <= cnt - W'(1);
      end
   end

endmodule

// File: rtl/iir_coef_ctrl.sv
// Coefficient shadow/active register pair for iir_filter with a commit
// sequence that stalls the stream, drains the filter and swaps atomically.
module iir_coef_ctrl
   import iir_pkg::*;
#(
   parameter int NB           = iir_pkg::NB,
   parameter int MAX_INFLIGHT = 7,
   parameter int CLR_CYCLES   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [2:0]      wr_addr,
   input  logic [NB-1:0]   wr_data,
   input  logic            commit,
   input  logic            commit_clr,
   output logic            busy,
   output logic            done,
   output logic            err,
   input  logic            s_vIn,
   input  logic [NB-1:0]   s_dIn,
   output logic            s_ready,
   output logic            f_vIn,
   output logic [NB-1:0]   f_dIn,
   input  logic            f_vOut,
   output logic            f_rst_n,
   output logic [3*NB-1:0] b,
   output logic [2*NB-1:0] a
);

   localparam int CW = $clog2(MAX_INFLIGHT + 1);
   localparam int KW = $clog2(CLR_CYCLES) + 1;

   state_t        state;
   logic          clr_lat;
   logic [KW-1:0] clr_cnt;
   logic [CW-1:0] cnt;
   logic          underflow;

   logic [NB-1:0] sh_b0, sh_b1, sh_b2, sh_a1, sh_a2;
   logic [NB-1:0] act_b0, act_b1, act_b2, act_a1, act_a2;

   inflight_cnt #(
      .MAX (MAX_INFLIGHT),
      .W   (CW)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (f_vIn),
      .dec       (f_vOut),
      .cnt       (cnt),
      .underflow (underflow)
   );

   assign s_ready = (state == RUN) & (cnt < CW'(MAX_INFLIGHT)) & ~rst;
   assign f_vIn   = s_vIn & s_ready;
   assign f_dIn   = s_dIn;
   assign busy    = (state != RUN);
   assign f_rst_n = ~rst & (state != CLEAR);
   assign b       = {act_b2, act_b1, act_b0};
   assign a       = {act_a2, act_a1};

   // Host writes land in shadow in every state; addresses past A_A2 are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_b0 <= '0;
         sh_b1 <= '0;
         sh_b2 <= '0;
         sh_a1 <= '0;
         sh_a2 <= '0;
      end else if (wr_en) begin
         case (wr_addr)
            A_B0:    sh_b0 <= wr_data;
            A_B1:    sh_b1 <= wr_data;
            A_B2:    sh_b2 <= wr_data;
            A_A1:    sh_a1 <= wr_data;
            A_A2:    sh_a2 <= wr_data;
            default: ;
         endcase
      end
   end

   // Commit sequence; active set copies shadow only at the end of SWAP, so a
   // write in the SWAP cycle itself stays in shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         clr_lat <= 1'b0;
         clr_cnt <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         act_b0  <= '0;
         act_b1  <= '0;
         act_b2  <= '0;
         act_a1  <= '0;
         act_a2  <= '0;
      end else begin
         done <= 1'b0;
         err  <= err | underflow;
         case (state)
            RUN: begin
               if (commit) begin
                  state   <= DRAIN;
                  clr_lat <= commit_clr;
               end
            end
            DRAIN: begin
               if (cnt == '0)
                  state <= SWAP;
            end
            SWAP: begin
               act_b0  <= sh_b0;
               act_b1  <= sh_b1;
               act_b2  <= sh_b2;
               act_a1  <= sh_a1;
               act_a2  <= sh_a2;
               clr_cnt <= '0;
               if (clr_lat) begin
                  state <= CLEAR;
               end else begin
                  state <= RUN;
                  done  <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_cnt == KW'(CLR_CYCLES - 1)) begin
                  state <= RUN;
                  done  <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + KW'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
